// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mips_defs : load/store encodings, LSU state type, op helpers      |
// | Revision  : 1.0                                                   |
// +------------------------------------------------------------------+
package mips_defs;

    localparam logic [2:0] LDST_LB  = 3'b000;
    localparam logic [2:0] LDST_LH  = 3'b001;
    localparam logic [2:0] LDST_LW  = 3'b010;
    localparam logic [2:0] LDST_LBU = 3'b011;
    localparam logic [2:0] LDST_LHU = 3'b100;
    localparam logic [2:0] LDST_SB  = 3'b101;
    localparam logic [2:0] LDST_SH  = 3'b110;
    localparam logic [2:0] LDST_SW  = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } lsu_state_t;

    function automatic logic is_load(input logic [2:0] ctrl);
        return ctrl <= LDST_LHU;
    endfunction

    function automatic logic is_store(input logic [2:0] ctrl);
        return ctrl >= LDST_SB;
    endfunction

    function automatic logic misaligned(input logic [2:0] ctrl, input logic [1:0] off);
        case (ctrl)
            LDST_LH, LDST_LHU, LDST_SH: return off[0];
            LDST_LW, LDST_SW:           return off != 2'b00;
            default:                    return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_align.sv
`default_nettype none
// +------------------------------------------------------------------+
// | lsu_align : big-endian store lane steering and load extraction    |
// | Revision  : 1.0                                                   |
// +------------------------------------------------------------------+
module lsu_align
    import mips_defs::*;
(
    input  logic [2:0]  st_ctrl,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_data,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    input  logic [2:0]  ld_ctrl,
    input  logic [1:0]  ld_off,
    input  logic [31:0] rdata,
    output logic [31:0] load_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        be    = 4'b1111;
        wdata = st_data;
        case (st_ctrl)
            LDST_SB: begin
                be    = 4'b1000 >> st_off;
                wdata = {4{st_data[7:0]}};
            end
            LDST_SH: begin
                be    = st_off[1] ? 4'b0011 : 4'b1100;
                wdata = {2{st_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Byte offset 0 lives in the most significant lane.
    always_comb begin
        case (ld_off)
            2'd0:    w_byte = rdata[31:24];
            2'd1:    w_byte = rdata[23:16];
            2'd2:    w_byte = rdata[15:8];
            default: w_byte = rdata[7:0];
        endcase
        w_half = ld_off[1] ? rdata[15:0] : rdata[31:16];
    end

    always_comb begin
        load_data = rdata;
        case (ld_ctrl)
            LDST_LB:  load_data = {{24{w_byte[7]}}, w_byte};
            LDST_LBU: load_data = {24'd0, w_byte};
            LDST_LH:  load_data = {{16{w_half[15]}}, w_half};
            LDST_LHU: load_data = {16'd0, w_half};
            default:  ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | load_store_unit : MEM-stage LSU with req/gnt/rvalid data port     |
// | Revision        : 1.0                                             |
// +------------------------------------------------------------------+
module load_store_unit
    import mips_defs::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic              ex_mem_write,
    input  logic              ex_mem_to_reg,
    input  logic [2:0]        ex_ldst_ctrl,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [DATA_W-1:0] ex_store_data,
    output logic              stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-3:0] dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_load_data,
    output logic              misalign_exc,
    output logic [ADDR_W-1:0] bad_vaddr
);

    lsu_state_t        r_state, w_state_next;
    logic [2:0]        r_ctrl;
    logic [1:0]        r_off;
    logic              w_op, w_misalign, w_accept;
    logic [3:0]        w_st_be;
    logic [DATA_W-1:0] w_st_wdata, w_ld_data;

    assign w_op       = ex_valid & (ex_mem_write | ex_mem_to_reg);
    assign w_misalign = misaligned(ex_ldst_ctrl, ex_addr[1:0]);
    assign w_accept   = (r_state == IDLE) & w_op & ~w_misalign;
    assign stall      = (r_state != IDLE) | w_accept;
    assign dmem_req   = (r_state == REQ);

    lsu_align u_align (
        .st_ctrl   (ex_ldst_ctrl),
        .st_off    (ex_addr[1:0]),
        .st_data   (ex_store_data),
        .be        (w_st_be),
        .wdata     (w_st_wdata),
        .ld_ctrl   (r_ctrl),
        .ld_off    (r_off),
        .rdata     (dmem_rdata),
        .load_data (w_ld_data)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_next = REQ;
            REQ:     if (dmem_gnt) w_state_next = is_load(r_ctrl) ? WAIT : IDLE;
            WAIT:    if (dmem_rvalid) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_ctrl       <= 3'd0;
            r_off        <= 2'd0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_be      <= 4'd0;
            dmem_wdata   <= '0;
            wb_valid     <= 1'b0;
            wb_load_data <= '0;
            misalign_exc <= 1'b0;
            bad_vaddr    <= '0;
        end else begin
            r_state      <= w_state_next;
            wb_valid     <= 1'b0;
            misalign_exc <= 1'b0;
            if ((r_state == IDLE) && w_op && w_misalign) begin
                misalign_exc <= 1'b1;
                bad_vaddr    <= ex_addr;
            end
            if (w_accept) begin
                r_ctrl     <= ex_ldst_ctrl;
                r_off      <= ex_addr[1:0];
                dmem_we    <= is_store(ex_ldst_ctrl);
                dmem_addr  <= ex_addr[ADDR_W-1:2];
                dmem_be    <= w_st_be;
                dmem_wdata <= w_st_wdata;
            end
            if ((r_state == WAIT) && dmem_rvalid) begin
                wb_load_data <= w_ld_data;
                wb_valid     <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
